// File: rtl/sprite_renderer_gen.sv
// rtl/sprite_renderer_gen.sv - scanline sprite renderer, one ROM row per line, with flips and done pulse
// Optional pixel/line doubling when SPRITE_ZOOM_EN is defined (adds the zoom input).
module sprite_renderer_gen #(
  parameter int W      = 8,
  parameter int H      = 16,
  parameter int MIRROR = 1,
  parameter int AW     = $clog2(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vstart,
  input  logic          load,
  input  logic          hstart,
  input  logic          hflip,
  input  logic          vflip,
`ifdef SPRITE_ZOOM_EN
  input  logic          zoom,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [W-1:0]  rom_bits,
  output logic          gfx,
  output logic          in_progress,
  output logic          done
);

  localparam int XW  = $clog2(2 * W) + 1;
  localparam int YW  = AW + 1;
  localparam int IW  = $clog2(W);
  localparam int LWI = (MIRROR != 0) ? 2 * W : W;

  localparam logic [XW-1:0] X_LAST   = XW'(LWI - 1);
  localparam logic [XW-1:0] X_LAST_Z = XW'(2 * LWI - 1);
  localparam logic [XW-1:0] W_X      = XW'(W);
  localparam logic [XW-1:0] W2M1     = XW'(2 * W - 1);
  localparam logic [XW-1:0] WM1      = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(H - 1);
  localparam logic [YW-1:0] Y_LAST_Z = YW'(2 * H - 1);
  localparam logic [AW-1:0] HM1      = AW'(H - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOAD   = 3'd1,
    SETUP       = 3'd2,
    FETCH       = 3'd3,
    WAIT_HSTART = 3'd4,
    DRAW        = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] xcount, xcount_n;
  logic [YW-1:0] ycount, ycount_n;
  logic [AW-1:0] rom_addr_n;
  logic [W-1:0]  row, row_n;
  logic          gfx_n, done_n;
  logic          hflip_l, hflip_n;
  logic          vflip_l, vflip_n;
  logic          zoom_l;

`ifdef SPRITE_ZOOM_EN
  always_ff @(posedge clk) begin
    if (reset)
      zoom_l <= 1'b0;
    else if (state == IDLE && vstart)
      zoom_l <= zoom;
  end
`else
  assign zoom_l = 1'b0;
`endif

  // Zoom halves both counters so each pixel and each ROM row is used twice.
  logic [XW-1:0] x_eff, pix_mir, x_last;
  logic [IW-1:0] pix_idx;
  logic [AW-1:0] y_row;
  logic [YW-1:0] y_last;

  always_comb begin
    x_eff   = zoom_l ? (xcount >> 1) : xcount;
    pix_mir = ((MIRROR != 0) && (x_eff >= W_X)) ? (W2M1 - x_eff) : x_eff;
    pix_idx = IW'(hflip_l ? (WM1 - pix_mir) : pix_mir);
    y_row   = AW'(zoom_l ? (ycount >> 1) : ycount);
    x_last  = zoom_l ? X_LAST_Z : X_LAST;
    y_last  = zoom_l ? Y_LAST_Z : Y_LAST;
  end

  always_comb begin
    state_n    = state;
    xcount_n   = xcount;
    ycount_n   = ycount;
    rom_addr_n = rom_addr;
    row_n      = row;
    gfx_n      = gfx;
    done_n     = 1'b0;
    hflip_n    = hflip_l;
    vflip_n    = vflip_l;
    case (state)
      IDLE: begin
        ycount_n = '0;
        gfx_n    = 1'b0;
        if (vstart) begin
          hflip_n = hflip;
          vflip_n = vflip;
          state_n = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        xcount_n = '0;
        gfx_n    = 1'b0;
        if (load)
          state_n = SETUP;
      end
      SETUP: begin
        rom_addr_n = vflip_l ? (HM1 - y_row) : y_row;
        state_n    = FETCH;
      end
      FETCH: begin
        row_n   = rom_bits;
        state_n = WAIT_HSTART;
      end
      WAIT_HSTART: begin
        gfx_n = 1'b0;
        if (hstart)
          state_n = DRAW;
      end
      DRAW: begin
        gfx_n    = row[pix_idx];
        xcount_n = xcount + 1'b1;
        if (xcount == x_last) begin
          ycount_n = ycount + 1'b1;
          if (ycount == y_last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = WAIT_LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      xcount   <= '0;
      ycount   <= '0;
      rom_addr <= '0;
      row      <= '0;
      gfx      <= 1'b0;
      done     <= 1'b0;
      hflip_l  <= 1'b0;
      vflip_l  <= 1'b0;
    end else begin
      state    <= state_n;
      xcount   <= xcount_n;
      ycount   <= ycount_n;
      rom_addr <= rom_addr_n;
      row      <= row_n;
      gfx      <= gfx_n;
      done     <= done_n;
      hflip_l  <= hflip_n;
      vflip_l  <= vflip_n;
    end
  end

  assign in_progress = (state != IDLE);

endmodule

// File: tb/tb_sprite_renderer_gen.sv
// tb/tb_sprite_renderer_gen.sv - directed bench for sprite_renderer_gen (mirrored and non-mirrored instances)
module tb_sprite_renderer_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vstart = 1'b0, load = 1'b0, hstart = 1'b0;
  logic       hflip = 1'b0, vflip = 1'b0, zoom = 1'b0;
  logic [3:0] addr_a, addr_b;
  logic [7:0] bits_a, bits_b;
  logic       gfx_a, gfx_b, prog_a, prog_b, done_a, done_b;
  int         total = 0;
  int         bad = 0;
  bit         zm = 1'b0;

  always #5 clk = ~clk;

  // Row r holds a single set bit at position r%8; the second ROM is constant 0000_0011.
  assign bits_a = 8'h01 << addr_a[2:0];
  assign bits_b = 8'b0000_0011;

  sprite_renderer_gen dut (
    .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
    .hflip(hflip), .vflip(vflip),
`ifdef SPRITE_ZOOM_EN
    .zoom(zoom),
`endif
    .rom_addr(addr_a), .rom_bits(bits_a), .gfx(gfx_a), .in_progress(prog_a), .done(done_a)
  );

  sprite_renderer_gen #(.MIRROR(0)) dut_m0 (
    .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
    .hflip(hflip), .vflip(vflip),
`ifdef SPRITE_ZOOM_EN
    .zoom(zoom),
`endif
    .rom_addr(addr_b), .rom_bits(bits_b), .gfx(gfx_b), .in_progress(prog_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One scanline starting in WAIT_LOAD; addr is the ROM row expected to be fetched.
  task automatic do_line(input int addr, input bit hf, input bit noise, input bit last);
    int          b;
    int          lw;
    int          kk;
    logic [15:0] ea;
    logic [7:0]  eb;
    b  = addr % 8;
    lw = zm ? 32 : 16;
    ea = hf ? ((16'h1 << (7 - b)) | (16'h1 << (8 + b)))
            : ((16'h1 << b) | (16'h8000 >> b));
    eb = hf ? 8'hC0 : 8'h03;
    if (noise) begin
      hstart = 1'b1;
      tick();
      hstart = 1'b0;
      chk("noise_prog", prog_a, 1'b1);
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk($sformatf("rom_addr_%0d", addr), addr_a, addr);
    tick();
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    for (int k = 0; k < lw; k++) begin
      if (noise && k == 2) begin
        vstart = 1'b1;
        hflip  = 1'b1;
      end
      tick();
      vstart = 1'b0;
      kk = zm ? (k >> 1) : k;
      chk($sformatf("gfx_a_r%0d_k%0d", addr, k), gfx_a, ea[kk]);
      chk($sformatf("gfx_b_r%0d_k%0d", addr, k), gfx_b, (kk < 8) ? eb[kk] : 1'b0);
    end
    chk($sformatf("done_r%0d", addr), done_a, last);
    tick();
    chk($sformatf("gfx_off_r%0d", addr), gfx_a, 1'b0);
    chk($sformatf("done_off_r%0d", addr), done_a, 1'b0);
    chk($sformatf("prog_r%0d", addr), prog_a, !last);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_gfx", gfx_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_prog", prog_a, 1'b0);
    chk("rst_addr", addr_a, 4'd0);
    chk("rst_prog_b", prog_b, 1'b0);

    // Plain mirrored sprite, top to bottom.
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    chk("start_prog", prog_a, 1'b1);
    for (int r = 0; r < 16; r++) do_line(r, 1'b0, 1'b0, r == 15);
    chk("end_prog_b", prog_b, 1'b0);

    // Vertical flip: rows fetched 15 down to 0.
    vflip  = 1'b1;
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    vflip  = 1'b0;
    for (int r = 0; r < 16; r++) do_line(15 - r, 1'b0, 1'b0, r == 15);

    // Horizontal flip, then reset in the middle of line 5.
    hflip  = 1'b1;
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    hflip  = 1'b0;
    for (int r = 0; r < 5; r++) do_line(r, 1'b1, 1'b0, 1'b0);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_gfx", gfx_a, 1'b0);
    chk("abort_prog", prog_a, 1'b0);
    chk("abort_done", done_a, 1'b0);
    chk("abort_gfx_b", gfx_b, 1'b0);
    chk("abort_prog_b", prog_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", done_a, 1'b0);
    end

    // Restart from row 0; line 3 carries a stray hstart and a stray vstart with hflip.
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    for (int r = 0; r < 16; r++) do_line(r, 1'b0, r == 3, r == 15);
    hflip = 1'b0;

`ifdef SPRITE_ZOOM_EN
    zoom   = 1'b1;
    zm     = 1'b1;
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    zoom   = 1'b0;
    for (int y = 0; y < 32; y++) do_line(y >> 1, 1'b0, 1'b0, y == 31);
    zm = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
